// File: rtl/wimax_verify_sequencer.sv
// wimax_verify_sequencer
//
// On-silicon stimulus sequencer for the WiMAX PHY verification top. Once the
// PLL reports lock it fires a single PRBS seed load strobe, then holds the
// chain enable for a fixed observation window while watching the four
// per-stage pass flags. At the end it latches one verdict that stays put for
// board LEDs or a scan readout until restart or reset.
//
// Optional feature macro: SEQ_STICKY_CHECK_EN
//   defined   : each stage flag must stay 1 on every RUN cycle from
//               GRACE_CYCLES to the end of the window (sticky check)
//   undefined : the flags are sampled on the final RUN cycle only and
//               GRACE_CYCLES only sizes the counter
//
// Parameters
//   LOCK_TIMEOUT  max cycles spent waiting for pll_locked
//   RUN_CYCLES    observation window length (cycles with en high in RUN)
//   GRACE_CYCLES  settle time after en rises before flags are checked
//                 (must be less than RUN_CYCLES)
//
// Ports
//   clk_ref           in   reference clock, the only clock
//   reset             in   asynchronous active-high reset
//   pll_locked        in   PLL lock indicator
//   restart           in   one-cycle pulse, re-runs from DONE or ERROR
//   prbs_pass         in   stage pass flags, synchronous to clk_ref
//   fec_pass          in
//   interleaver_pass  in
//   modulator_pass    in
//   load              out  PRBS seed load strobe (one cycle)
//   en                out  PRBS / chain enable
//   done              out  verdict valid
//   all_pass          out  all four stages passed (valid with done)
//   stage_status[3:0] out  {modulator, interleaver, fec, prbs}
//   err_code[1:0]     out  00 none, 01 lock timeout, 10 lock lost in run

module wimax_verify_sequencer #(
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned RUN_CYCLES   = 1250,
  parameter int unsigned GRACE_CYCLES = 256
) (
  input  logic       clk_ref,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       restart,
  input  logic       prbs_pass,
  input  logic       fec_pass,
  input  logic       interleaver_pass,
  input  logic       modulator_pass,
  output logic       load,
  output logic       en,
  output logic       done,
  output logic       all_pass,
  output logic [3:0] stage_status,
  output logic [1:0] err_code
);

  // The counter must reach the largest terminal count it is compared with.
  localparam int unsigned SPAN_LR = (LOCK_TIMEOUT > RUN_CYCLES) ? LOCK_TIMEOUT : RUN_CYCLES;
  localparam int unsigned SPAN    = (SPAN_LR > GRACE_CYCLES) ? SPAN_LR : GRACE_CYCLES;
  localparam int unsigned CW      = (SPAN > 2) ? $clog2(SPAN) : 1;

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] RUN_LAST  = CW'(RUN_CYCLES - 1);

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_LOCK_TIME = 2'b01;
  localparam logic [1:0] ERR_LOCK_LOST = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOCK,
    LOAD,
    RUN,
    DONE,
    ERROR
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [1:0]      err_kind;
  logic [3:0]      verdict;
  logic [3:0]      flags;
  logic [3:0]      final_flags;

  logic            load_d;
  logic            en_d;
  logic            done_d;
  logic [3:0]      stage_d;
  logic [1:0]      err_d;

  assign flags = {modulator_pass, interleaver_pass, fec_pass, prbs_pass};

`ifdef SEQ_STICKY_CHECK_EN
  localparam logic [CW-1:0] GRACE_START = CW'(GRACE_CYCLES);

  logic [3:0] sticky;

  // Sticky pass bits: armed during LOAD, and any 0 seen inside the checked
  // part of the window clears that stage for the rest of the run.
  always_ff @(posedge clk_ref or posedge reset) begin
    if (reset) begin
      sticky <= 4'h0;
    end else if (state == LOAD) begin
      sticky <= 4'hF;
    end else if ((state == RUN) && (cnt >= GRACE_START)) begin
      sticky <= sticky & flags;
    end
  end

  // The final cycle's flags are folded in here since sticky has not seen them yet.
  assign final_flags = sticky & flags;
`else
  assign final_flags = flags;
`endif

  // State register.
  always_ff @(posedge clk_ref or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. In WAIT_LOCK a lock on the timeout cycle still wins;
  // in RUN a lock drop on the final cycle still goes to ERROR.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      state_nxt = WAIT_LOCK;
      WAIT_LOCK: begin
        if (pll_locked) begin
          state_nxt = LOAD;
        end else if (cnt == LOCK_LAST) begin
          state_nxt = ERROR;
        end
      end
      LOAD:      state_nxt = RUN;
      RUN: begin
        if (!pll_locked) begin
          state_nxt = ERROR;
        end else if (cnt == RUN_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE, ERROR: begin
        if (restart) begin
          state_nxt = WAIT_LOCK;
        end
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // Output decode from the current state; registered below so every output
  // comes straight from a flop.
  always_comb begin
    load_d  = (state == LOAD);
    en_d    = (state == RUN) || (state == DONE);
    done_d  = (state == DONE) || (state == ERROR);
    stage_d = (state == DONE) ? verdict : 4'h0;
    err_d   = (state == ERROR) ? err_kind : ERR_NONE;
  end

  // Output registers.
  always_ff @(posedge clk_ref or posedge reset) begin
    if (reset) begin
      load         <= 1'b0;
      en           <= 1'b0;
      done         <= 1'b0;
      all_pass     <= 1'b0;
      stage_status <= 4'h0;
      err_code     <= ERR_NONE;
    end else begin
      load         <= load_d;
      en           <= en_d;
      done         <= done_d;
      all_pass     <= &stage_d;
      stage_status <= stage_d;
      err_code     <= err_d;
    end
  end

  // Cycle counter: counts only while waiting for lock or running, and clears
  // on every state change so each phase starts from zero.
  always_ff @(posedge clk_ref or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if ((state == WAIT_LOCK) || (state == RUN)) begin
      cnt <= cnt + CNT_ONE;
    end else begin
      cnt <= '0;
    end
  end

  // Verdict and error cause, captured on the transition that decides them.
  always_ff @(posedge clk_ref or posedge reset) begin
    if (reset) begin
      verdict  <= 4'h0;
      err_kind <= ERR_NONE;
    end else begin
      unique case (state)
        WAIT_LOCK: begin
          if (!pll_locked && (cnt == LOCK_LAST)) begin
            err_kind <= ERR_LOCK_TIME;
          end
        end
        RUN: begin
          if (!pll_locked) begin
            err_kind <= ERR_LOCK_LOST;
          end
          if (cnt == RUN_LAST) begin
            verdict <= final_flags;
          end
        end
        DONE, ERROR: begin
          if (restart) begin
            err_kind <= ERR_NONE;
            verdict  <= 4'h0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wimax_verify_sequencer.sv
// tb_wimax_verify_sequencer
//
// Self-checking bench for wimax_verify_sequencer with LOCK_TIMEOUT=16,
// RUN_CYCLES=32, GRACE_CYCLES=8. A timeline model driven by the same inputs
// predicts every output on every cycle; directed scenarios add hand-computed
// latencies and verdicts, then a randomized phase stresses lock drops, flag
// glitches, restarts and asynchronous resets.

module tb_wimax_verify_sequencer;

  localparam int LT = 16;
  localparam int RC = 32;
  localparam int GR = 8;

  logic       clk_ref = 1'b0;
  logic       reset = 1'b1;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       prbs_pass = 1'b1;
  logic       fec_pass = 1'b1;
  logic       interleaver_pass = 1'b1;
  logic       modulator_pass = 1'b1;
  logic       load;
  logic       en;
  logic       done;
  logic       all_pass;
  logic [3:0] stage_status;
  logic [1:0] err_code;

  int n_checks = 0;
  int n_fails = 0;
  bit model_on = 1'b0;

  wimax_verify_sequencer #(
    .LOCK_TIMEOUT(LT),
    .RUN_CYCLES(RC),
    .GRACE_CYCLES(GR)
  ) dut (
    .clk_ref(clk_ref),
    .reset(reset),
    .pll_locked(pll_locked),
    .restart(restart),
    .prbs_pass(prbs_pass),
    .fec_pass(fec_pass),
    .interleaver_pass(interleaver_pass),
    .modulator_pass(modulator_pass),
    .load(load),
    .en(en),
    .done(done),
    .all_pass(all_pass),
    .stage_status(stage_status),
    .err_code(err_code)
  );

  always #10 clk_ref = ~clk_ref;

  // One comparison: counts it and reports a mismatch.
  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
    n_checks++;
    if (actual !== required) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, required, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Timeline model. 'act' says what the sequence is doing in the current
  // cycle (I idle, W waiting, L load, R run, D done, E error); outputs seen
  // in a cycle describe the activity of the cycle before.
  // ---------------------------------------------------------------------
  logic [7:0] act = "I";
  int         cyc = 0;
  int         w0 = 0;
  int         r0 = 0;
  logic [1:0] m_err = 2'b00;
  logic [3:0] m_verdict = 4'h0;
  logic [3:0] hist [RC];
  logic       exp_load = 1'b0;
  logic       exp_en = 1'b0;
  logic       exp_done = 1'b0;
  logic       exp_allp = 1'b0;
  logic [3:0] exp_stage = 4'h0;
  logic [1:0] exp_err = 2'b00;

  task automatic model_step();
    logic [3:0] fl;
    logic [3:0] v;
    int rel;
    if (reset) begin
      act = "I";
      m_err = 2'b00;
      exp_load = 1'b0;
      exp_en = 1'b0;
      exp_done = 1'b0;
      exp_allp = 1'b0;
      exp_stage = 4'h0;
      exp_err = 2'b00;
      return;
    end
    fl = {modulator_pass, interleaver_pass, fec_pass, prbs_pass};
    exp_load  = (act == "L");
    exp_en    = (act == "R") || (act == "D");
    exp_done  = (act == "D") || (act == "E");
    exp_stage = (act == "D") ? m_verdict : 4'h0;
    exp_allp  = (act == "D") && (m_verdict == 4'hF);
    exp_err   = (act == "E") ? m_err : 2'b00;
    case (act)
      "I": begin
        act = "W";
        w0 = cyc + 1;
      end
      "W": begin
        if (pll_locked) begin
          act = "L";
        end else if (cyc - w0 == LT - 1) begin
          act = "E";
          m_err = 2'b01;
        end
      end
      "L": begin
        act = "R";
        r0 = cyc + 1;
      end
      "R": begin
        rel = cyc - r0;
        if (rel >= 0 && rel < RC) hist[rel] = fl;
        if (!pll_locked) begin
          act = "E";
          m_err = 2'b10;
        end else if (rel == RC - 1) begin
`ifdef SEQ_STICKY_CHECK_EN
          v = 4'hF;
          for (int k = GR; k < RC; k++) v = v & hist[k];
`else
          v = hist[RC-1];
`endif
          m_verdict = v;
          act = "D";
        end
      end
      default: begin
        if (restart) begin
          act = "W";
          w0 = cyc + 1;
          m_err = 2'b00;
        end
      end
    endcase
    cyc++;
  endtask

  initial begin
    forever begin
      @(posedge clk_ref or posedge reset);
      model_step();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk_ref);
      if (model_on) begin
        check_output("load", load, exp_load);
        check_output("en", en, exp_en);
        check_output("done", done, exp_done);
        check_output("all_pass", all_pass, exp_allp);
        check_output("stage_status", stage_status, exp_stage);
        check_output("err_code", err_code, exp_err);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  function automatic logic get_sig(input int which);
    case (which)
      0:       return load;
      1:       return en;
      default: return done;
    endcase
  endfunction

  // Index (0 = current cycle) of the first cycle where the chosen output is 1.
  task automatic wait_sig(input int which, input int limit, output int idx);
    idx = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_ref);
      if (get_sig(which)) begin
        idx = i;
        break;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_ref);
    #1;
  endtask

  // Drives the run window cycle by cycle (i = 0 is the first en cycle, which
  // is RUN count 1) and counts en / load cycles until done appears.
  task automatic apply_stimulus(input int glitch_i, input int restart_i, input int drop_i,
                                output int n_en, output int n_load);
    n_en = 0;
    n_load = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      fec_pass = (i != glitch_i);
      restart = (i == restart_i);
      if (drop_i >= 0 && i >= drop_i) pll_locked = 1'b0;
      @(negedge clk_ref);
      if (done) break;
      if (en) n_en++;
      if (load) n_load++;
    end
    restart = 1'b0;
    fec_pass = 1'b1;
  endtask

  task automatic pulse_restart(input logic lock);
    tick();
    restart = 1'b1;
    pll_locked = lock;
    tick();
    restart = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idx;
    int n_en;
    int n_load;
    logic lk;

    // Reset values
    @(negedge clk_ref);
    @(negedge clk_ref);
    check_output("rst_load", load, 0);
    check_output("rst_en", en, 0);
    check_output("rst_done", done, 0);
    check_output("rst_all_pass", all_pass, 0);
    check_output("rst_stage", stage_status, 4'h0);
    check_output("rst_err", err_code, 2'b00);
    model_on = 1'b1;

    // Nominal run: lock at cycle 5, all flags good
    $display("[TB] nominal run");
    tick();
    reset = 1'b0;
    repeat (5) tick();
    pll_locked = 1'b1;
    wait_sig(0, 12, idx);
    check_output("s1_load_latency", idx, 2);
    apply_stimulus(-1, -1, -1, n_en, n_load);
    check_output("s1_en_cycles", n_en, 32);
    check_output("s1_extra_load", n_load, 0);
    check_output("s1_done", done, 1);
    check_output("s1_en_in_done", en, 1);
    check_output("s1_stage", stage_status, 4'b1111);
    check_output("s1_all_pass", all_pass, 1);
    check_output("s1_err", err_code, 2'b00);

    // Restart from DONE, fec glitch at RUN count 20, ignored restart in RUN
    $display("[TB] restart with fec glitch");
    pulse_restart(1'b1);
    wait_sig(0, 12, idx);
    check_output("s2_load_latency", idx, 2);
    apply_stimulus(19, 5, -1, n_en, n_load);
    check_output("s2_en_cycles", n_en, 32);
    check_output("s2_extra_load", n_load, 0);
    check_output("s2_done", done, 1);
`ifdef SEQ_STICKY_CHECK_EN
    check_output("s2_stage", stage_status, 4'b1101);
    check_output("s2_all_pass", all_pass, 0);
`else
    check_output("s2_stage", stage_status, 4'b1111);
    check_output("s2_all_pass", all_pass, 1);
`endif

    // Lock never arrives
    $display("[TB] lock timeout");
    tick();
    reset = 1'b1;
    pll_locked = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    wait_sig(2, 30, idx);
    check_output("s3_done_latency", idx, 18);
    check_output("s3_err", err_code, 2'b01);
    check_output("s3_en", en, 0);
    check_output("s3_all_pass", all_pass, 0);

    // Lock lost at RUN count 10
    $display("[TB] lock lost during run");
    pulse_restart(1'b1);
    wait_sig(0, 12, idx);
    check_output("s4_load_latency", idx, 2);
    apply_stimulus(-1, -1, 9, n_en, n_load);
    check_output("s4_en_cycles", n_en, 11);
    check_output("s4_done", done, 1);
    check_output("s4_err", err_code, 2'b10);
    check_output("s4_en", en, 0);
    check_output("s4_stage", stage_status, 4'h0);
    check_output("s4_all_pass", all_pass, 0);

    // Reset in the middle of RUN
    $display("[TB] reset mid-run");
    pulse_restart(1'b1);
    wait_sig(1, 12, idx);
    check_output("s5_en_latency", idx, 3);
    repeat (5) tick();
    #2;
    reset = 1'b1;
    #1;
    check_output("s5_rst_load", load, 0);
    check_output("s5_rst_en", en, 0);
    check_output("s5_rst_done", done, 0);
    check_output("s5_rst_stage", stage_status, 4'h0);
    check_output("s5_rst_err", err_code, 2'b00);
    tick();
    reset = 1'b0;
    wait_sig(0, 12, idx);
    check_output("s5_load_after_reset", idx, 3);
    apply_stimulus(-1, -1, -1, n_en, n_load);
    check_output("s5_en_cycles", n_en, 32);
    check_output("s5_stage", stage_status, 4'b1111);

    // Randomized traffic
    $display("[TB] random phase");
    for (int i = 0; i < 2500; i++) begin
      tick();
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(0, 399) == 0) begin
        #2;
        reset = 1'b1;
      end
      lk = pll_locked;
      if (lk) pll_locked = ($urandom_range(0, 59) != 0);
      else    pll_locked = ($urandom_range(0, 7) == 0);
      prbs_pass        = ($urandom_range(0, 47) != 0);
      fec_pass         = ($urandom_range(0, 47) != 0);
      interleaver_pass = ($urandom_range(0, 47) != 0);
      modulator_pass   = ($urandom_range(0, 47) != 0);
      restart          = ($urandom_range(0, 15) == 0);
    end
    tick();
    reset = 1'b0;
    restart = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
